time_counter: RTL and testbench
===============================

// Module: time_counter
// PURPOSE
// - Free-running elapsed-time counter: counter advances one count per tick
//   while the design is out of reset.
// - Tick = PRESCALE clock cycles (default 1, so one count per clock).
// - Wraps from MAX_COUNT to 0 by default.
// - Used as a simple timebase/timestamp source. The control logic that
//   drives reset_start starts the count by releasing reset.
// PARAMETERS
// - WIDTH      8    counter width in bits
// - MAX_COUNT  255  terminal count; must be <= 2**WIDTH-1 and >= 1
// - PRESCALE   1    clocks per count; must be >= 1
//                   (1 = no prescaler; prescaler logic optimised away)
// PORTS
// - clock        in   1      single clock; all state updates on rising edge
// - reset_start  in   1      asynchronous, active-low reset; 0 = clear/hold,
//                            1 = count
// - counter      out  WIDTH  current count, registered output
// BEHAVIOUR
// - Reset and clocking: one clock; reset is asynchronous and active-low.
// - Reset (reset_start=0):
//   - Asserts asynchronously, without waiting for a clock edge.
//   - counter=0 and the internal prescaler count=0 immediately.
//   - Both are held at 0 for as long as reset_start is low.
// - Run (reset_start=1):
//   - Prescaler counts 0..PRESCALE-1. A tick occurs on the edge where the
//     prescaler is at PRESCALE-1; the prescaler then returns to 0.
//   - With PRESCALE=1, every rising edge is a tick.
//   - On a tick:
//     - If counter < MAX_COUNT: counter <= counter+1.
//     - If counter == MAX_COUNT: counter <= 0 (wrap).
//   - Between ticks, counter holds its value.
// - Latency:
//   - First increment happens on the PRESCALE-th rising edge after reset
//     release.
//   - With PRESCALE=1, counter reads 1 after the first edge following
//     release.
// - Reset release:
//   - Deassertion is used directly (no synchronizer).
//   - Stimulus must release reset away from the rising clock edge.
//   - Deassertion coincident with an edge gives an undefined first count.
// - Reset mid-operation:
//   - Clears counter and prescaler immediately.
//   - Counting resumes from 0 with full prescaler latency.
// - Arithmetic:
//   - Unsigned, WIDTH bits.
//   - The increment never overflows WIDTH, because the wrap at MAX_COUNT is
//     checked before adding.
// - counter is driven straight from a flop (no combinational output path).
// CONFIGURATION
// - Macro TIME_CNT_SATURATE_EN.
// - Defined: on a tick at counter==MAX_COUNT, counter stays at MAX_COUNT
//   (saturates). Only reset clears it.
// - Undefined (default): counter wraps MAX_COUNT -> 0 as described above.
// - Reset and prescaler behaviour are identical in both builds.
// TESTING
// Defaults unless noted; 10 ns clock; reset released at 25 ns, away from a
// rising edge.
// - Reset hold: reset_start=0 for 3 clocks -> counter=0 throughout, no X
//   after time 0.
// - Count up: release reset -> counter=1,2,3,... on successive edges;
//   counter=100 on the 100th edge.
// - Wrap: run 260 edges -> counter reads 255 on edge 255, 0 on edge 256,
//   4 on edge 260.
// - Async reset mid-run: drop reset_start at counter=57, mid-cycle ->
//   counter=0 before the next edge; after re-release, 1 on the first edge.
// - Prescale: PRESCALE=4, MAX_COUNT=9 -> increments every 4th edge;
//   9 -> 0 after 40 edges.
// - Saturate (TIME_CNT_SATURATE_EN): WIDTH=4, MAX_COUNT=15 -> counter=15
//   from edge 15 onward; reset returns it to 0.

Source files
------------

// File: rtl/time_counter.sv
// time_counter: free-running elapsed-time counter with optional prescaler.
// Define TIME_CNT_SATURATE_EN to hold at MAX_COUNT instead of wrapping to 0.
module time_counter #(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255,
   parameter int PRESCALE  = 1
) (
   input  logic             clock,
   input  logic             reset_start,
   output logic [WIDTH-1:0] counter
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
`ifdef TIME_CNT_SATURATE_EN
   localparam logic [WIDTH-1:0] TERM_NEXT = MAX;
`else
   localparam logic [WIDTH-1:0] TERM_NEXT = '0;
`endif
   logic tick;
   generate
      if (PRESCALE > 1) begin : g_pre
         localparam int PW = $clog2(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
         logic [PW-1:0] pre;
         always_ff @(posedge clock or negedge reset_start)
            if (!reset_start) pre <= '0;
            else pre <= (pre == LAST) ? '0 : pre + PW'(1);
         assign tick = (pre == LAST);
      end else begin : g_nopre
         assign tick = 1'b1;
      end
   endgenerate
   always_ff @(posedge clock or negedge reset_start)
      if (!reset_start) counter <= '0;
      else if (tick) counter <= (counter == MAX) ? TERM_NEXT : counter + WIDTH'(1);
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: checks time_counter (default and prescaled instances)
// against an edge-count model plus hand-computed literals.
module tb_time_counter;
   logic       clock = 1'b1;
   logic       reset_start = 1'b0;
   logic [7:0] counter;
   logic [3:0] counter_p;
   int         n = 0;
   int         errors = 0;
   int         checks = 0;

   time_counter dut (.clock(clock), .reset_start(reset_start), .counter(counter));
   time_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(4))
      dut_p (.clock(clock), .reset_start(reset_start), .counter(counter_p));

   always #5 clock = ~clock;

`ifdef TIME_CNT_SATURATE_EN
   localparam int E256 = 255, E260 = 255, E313 = 255, P40 = 9, P260 = 9;
`else
   localparam int E256 = 0, E260 = 4, E313 = 57, P40 = 0, P260 = 5;
`endif

   // Count expected after n ticks-worth of edges since release.
   function automatic int expect_cnt(int edges, int p, int mx);
      int t = edges / p;
`ifdef TIME_CNT_SATURATE_EN
      return (t > mx) ? mx : t;
`else
      return t % (mx + 1);
`endif
   endfunction

   task automatic chk(string name, logic [31:0] act, int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge reset_start) n = 0;

   always @(posedge clock) begin
      n = reset_start ? n + 1 : 0;
      #1;
      chk("model_cnt", {24'd0, counter}, expect_cnt(n, 1, 255));
      chk("model_cnt_p", {28'd0, counter_p}, expect_cnt(n, 4, 9));
   end

   task automatic edges(int k);
      repeat (k) @(posedge clock);
      #2;
   endtask

   initial begin
      #2;
      chk("reset_t2", {24'd0, counter}, 0);
      #23 reset_start = 1'b1;
      edges(1);
      chk("first_edge", {24'd0, counter}, 1);
      chk("first_edge_p", {28'd0, counter_p}, 0);
      edges(35);
      chk("edge36_p", {28'd0, counter_p}, 9);
      edges(4);
      chk("edge40_p", {28'd0, counter_p}, P40);
      edges(60);
      chk("edge100", {24'd0, counter}, 100);
      edges(155);
      chk("edge255", {24'd0, counter}, 255);
      edges(1);
      chk("edge256", {24'd0, counter}, E256);
      edges(4);
      chk("edge260", {24'd0, counter}, E260);
      chk("edge260_p", {28'd0, counter_p}, P260);
      edges(53);
      chk("edge313", {24'd0, counter}, E313);
      #2 reset_start = 1'b0;
      #1;
      chk("async_clr", {24'd0, counter}, 0);
      chk("async_clr_p", {28'd0, counter_p}, 0);
      edges(2);
      chk("hold", {24'd0, counter}, 0);
      #3 reset_start = 1'b1;
      edges(1);
      chk("rerelease1", {24'd0, counter}, 1);
      edges(2);
      chk("rerelease3_p", {28'd0, counter_p}, 0);
      edges(1);
      chk("rerelease4_p", {28'd0, counter_p}, 1);
      edges(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
